// File: rtl/tdm_demux_pkg.sv
// Shared constants and FSM state type for the TDM demultiplexer.
// Imported by the top module.
package tdm_demux_pkg;
  localparam int WIDTH = 4;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects four serialized slot words into shadow registers
// and loads the a..d lanes atomically when the slot-3 word arrives.
module tdm_demux #(
  parameter int WIDTH = tdm_demux_pkg::WIDTH,
  parameter int LANES = tdm_demux_pkg::LANES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       sof,
  input  logic                       enable,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  output logic [WIDTH-1:0]           d,
  output logic [1:0]                 sel,
  output logic                       frame_done,
  output logic                       frame_err,
  output tdm_demux_pkg::state_t      dbg_state
);
  import tdm_demux_pkg::*;

  // Handshake: a word is accepted on a rising edge when din_valid=1 and
  // enable=0; there is no backpressure, and sof is ignored unless din_valid=1.

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [WIDTH-1:0]   r_shadow [LANES-1];
  logic [LANES-2:0]   w_shadow_we;
  logic               w_load;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_c, r_d;
  logic               r_done, r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_shadow_we = '0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (enable) begin
      w_state_nxt = IDLE;
      w_sel_nxt   = '0;
    end else if (din_valid) begin
      case (r_state)
        IDLE: begin
          if (sof) begin
            w_shadow_we[0] = 1'b1;
            w_sel_nxt      = 2'd1;
            w_state_nxt    = RECV;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        RECV: begin
          if (sof) begin
            // Early sof restarts the frame with this word as slot 0.
            w_err_nxt      = 1'b1;
            w_shadow_we[0] = 1'b1;
            w_sel_nxt      = 2'd1;
          end else if (r_sel == 2'd3) begin
            w_load      = 1'b1;
            w_done_nxt  = 1'b1;
            w_sel_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_shadow_we[r_sel] = 1'b1;
            w_sel_nxt          = r_sel + 2'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      for (int i = 0; i < LANES - 1; i++) r_shadow[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (enable) begin
        r_a <= '0;
        r_b <= '0;
        r_c <= '0;
        r_d <= '0;
        for (int i = 0; i < LANES - 1; i++) r_shadow[i] <= '0;
      end else begin
        for (int i = 0; i < LANES - 1; i++) begin
          if (w_shadow_we[i]) r_shadow[i] <= din;
        end
        // Slot 3 bypasses the shadow so the lanes update in the accepting edge.
        if (w_load) begin
          r_a <= r_shadow[0];
          r_b <= r_shadow[1];
          r_c <= r_shadow[2];
          r_d <= din;
        end
      end
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign c          = r_c;
  assign d          = r_d;
  assign sel        = r_sel;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed bench for tdm_demux with a frame-level reference
// model and a scoreboard of expected frame_done/frame_err pulses.
module tb_tdm_demux;
  import tdm_demux_pkg::*;

  localparam int W  = 4;
  localparam int EW = 32 + 1 + 4 * W;  // {cycle, is_done, a,b,c,d}

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic         frame_done, frame_err;
  state_t       dbg_state;

  tdm_demux #(.WIDTH(W), .LANES(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sof(sof),
    .enable(enable), .a(a), .b(b), .c(c), .d(d), .sel(sel),
    .frame_done(frame_done), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model: words of the frame in progress, current lane contents.
  logic [W-1:0]  words[$];
  logic [W-1:0]  m_out[4] = '{default: '0};
  int            m_sel = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_evt(input bit is_done);
    exp_q.push_back({32'(cyc + 1), is_done, m_out[0], m_out[1], m_out[2], m_out[3]});
  endtask

  task automatic model_step(input logic rst, input logic en, input logic v,
                            input logic s, input logic [W-1:0] dd);
    if (rst || en) begin
      words.delete();
      m_out = '{default: '0};
    end else if (v) begin
      if (s) begin
        if (words.size() > 0) push_evt(1'b0);
        words.delete();
        words.push_back(dd);
      end else if (words.size() == 0) begin
        push_evt(1'b0);
      end else begin
        words.push_back(dd);
        if (words.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = words[i];
          words.delete();
          push_evt(1'b1);
        end
      end
    end
    m_sel = words.size();
  endtask

  task automatic drive(input logic rst, input logic en, input logic v,
                       input logic s, input logic [W-1:0] dd);
    @(negedge clk);
    reset = rst; enable = en; din_valid = v; sof = s; din = dd;
    model_step(rst, en, v, s, dd);
  endtask

  task automatic word(input logic s, input logic [W-1:0] dd);
    drive(1'b0, 1'b0, 1'b1, s, dd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
  endtask

  task automatic frame(input logic [W-1:0] w0, w1, w2, w3);
    word(1'b1, w0); word(1'b0, w1); word(1'b0, w2); word(1'b0, w3);
  endtask

  // Monitor: lane/sel state every cycle, pulses against the scoreboard.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (mon_en) begin
      chk("sel", 32'(sel), 32'(m_sel));
      chk("a", 32'(a), 32'(m_out[0]));
      chk("b", 32'(b), 32'(m_out[1]));
      chk("c", 32'(c), 32'(m_out[2]));
      chk("d", 32'(d), 32'(m_out[3]));
      chk("pulse_exclusive", 32'(frame_done & frame_err), 32'd0);
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
        e = exp_q.pop_front();
        chk(e[4*W] ? "missed_frame_done" : "missed_frame_err", 32'd0, 32'd1);
      end
      if (frame_done || frame_err) begin
        if (exp_q.size() == 0 || int'(exp_q[0][EW-1 -: 32]) != cyc) begin
          chk("unexpected_pulse", {30'd0, frame_done, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {30'd0, frame_done, frame_err}, {30'd0, e[4*W], ~e[4*W]});
          if (e[4*W]) chk("frame_data", 32'({a, b, c, d}), 32'(e[4*W-1:0]));
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h7);
    idle(2);
    // Single frame, then back-to-back frames.
    frame(4'h1, 4'h2, 4'h3, 4'h4);
    idle(2);
    frame(4'h5, 4'h6, 4'h7, 4'h8);
    frame(4'h9, 4'hA, 4'hB, 4'hC);
    idle(2);
    // Early sof.
    word(1'b1, 4'h1); word(1'b0, 4'h2);
    frame(4'h3, 4'h4, 4'h5, 4'h6);
    idle(2);
    // Orphan word, then a frame with gaps.
    word(1'b0, 4'hD);
    idle(2);
    word(1'b1, 4'h2); idle(2); word(1'b0, 4'h4); idle(1);
    word(1'b0, 4'h6); idle(3); word(1'b0, 4'h8);
    idle(2);
    // Disable mid-frame.
    frame(4'h1, 4'h2, 4'h3, 4'h4);
    word(1'b1, 4'hE); word(1'b0, 4'hF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h9);
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    idle(2);
    // Reset mid-frame, then an orphan word.
    word(1'b1, 4'h3); word(1'b0, 4'h5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
    word(1'b0, 4'h7);
    idle(2);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_en, r_v, r_s;
      r_rst = ($urandom_range(0, 199) < 2);
      r_en  = ($urandom_range(0, 99) < 3);
      r_v   = ($urandom_range(0, 99) < 75);
      r_s   = (words.size() == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
      drive(r_rst, r_en, r_v, r_s, W'($urandom_range(0, 15)));
    end
    idle(4);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter WIDTH, default 4, lane/data word width in bits.
REQ-002 Parameter LANES, default 4, number of output lanes; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 din  input  WIDTH  serialized data word, one lane per accepted word.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 sof  input  1  start of frame; qualified by din_valid; marks din as the slot-0 word.
REQ-008 enable  input  1  active-low block enable; 0 = operate, 1 = disabled.
REQ-009 a, b, c, d  output  WIDTH each  registered lanes for slots 0, 1, 2, 3.
REQ-010 sel  output  2  registered index of the next expected slot.
REQ-011 frame_done  output  1  one-cycle pulse when a, b, c, d have been updated with a complete frame.
REQ-012 frame_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-013 Block SHALL implement a two-state FSM: IDLE (await sof) and RECV (collecting slots 1..3).
REQ-014 In IDLE, din_valid=1 and sof=1 with enable=0 SHALL store din in shadow slot 0, set sel=1, and move to RECV.
REQ-015 In IDLE, din_valid=1 and sof=0 SHALL discard din, pulse frame_err next cycle, and stay in IDLE.
REQ-016 In RECV, din_valid=1 and sof=0 SHALL store din in shadow slot sel and increment sel.
REQ-017 When the slot-3 word is accepted, the block SHALL load a, b, c, d from shadow slots 0..2 and din in one edge, pulse frame_done in that same cycle, set sel=0, and return to IDLE.
REQ-018 Latency SHALL be 1 cycle from acceptance of the slot-3 word to a..d and frame_done being valid; a..d SHALL change only on frame completion, never partially.
REQ-019 In RECV, din_valid=1 and sof=1 SHALL pulse frame_err, discard the partial frame, store din as slot 0, set sel=1, and stay in RECV.
REQ-020 din_valid=0 SHALL hold all state; no timeout exists.
REQ-021 sof=1 with din_valid=0 SHALL be ignored.
REQ-022 An sof word in the cycle immediately after frame completion SHALL be accepted with no bubble, allowing back-to-back frames every 4 valid cycles.
REQ-023 enable=1 at an edge SHALL clear a, b, c, d and sel to 0, force IDLE, discard shadow contents, suppress frame_done and frame_err, and ignore din.
REQ-024 enable SHALL take priority over din_valid and sof; reset SHALL take priority over enable.
REQ-025 frame_done and frame_err SHALL never both be 1 in the same cycle.

Reset
REQ-026 On reset=1 at an edge: a=b=c=d=0, sel=0, frame_done=0, frame_err=0, shadow=0, state IDLE.
REQ-027 Reset asserted mid-frame SHALL abandon the partial frame with no pulse; the first accepted word after reset SHALL be an sof.

Structure
REQ-028 Shared package tdm_demux_pkg SHALL hold WIDTH, LANES, the slot-index width (2), and the FSM state type {IDLE, RECV}.
REQ-029 The block SHALL be a single module containing the FSM, the slot counter, the shadow registers, and the output registers; no sub-module is required.

Verification
REQ-030 Single frame: with enable=0, send 1,2,3,4 (first with sof) on consecutive cycles -> next cycle a=1, b=2, c=3, d=4, frame_done=1 for one cycle, sel=0.
REQ-031 Back-to-back frames: frames 5,6,7,8 and 9,A,B,C with no gaps -> frame_done pulses 4 cycles apart; a..d read 5,6,7,8 and then 9,A,B,C.
REQ-032 Early sof: send sof 1, then 2, then sof 3, 4, 5, 6 -> frame_err pulses once after the second sof; result a=3, b=4, c=5, d=6.
REQ-033 Gaps and orphan word: a word with sof=0 in IDLE -> frame_err pulse, outputs unchanged; a frame with din_valid=0 gaps between words -> completes correctly, sel holds during the gaps.
REQ-034 Disable mid-frame: with a..d=1,2,3,4, send sof E, F, then enable=1 for 1 cycle -> a..d=0, sel=0, no pulses; a following full frame completes normally.
REQ-035 Reset mid-frame: assert reset after 2 words -> all outputs 0 next cycle; a word with sof=0 then pulses frame_err.
